// File: rtl/i2c_cfg_slave.sv
// ---------------------------------------------------------------------------
// i2c_cfg_slave
//   Write-only I2C target for register configuration traffic. It oversamples
//   SCL/SDA on iCLK and accepts frames of the form
//   [SLAVE_ADDR+W, SUB_ADDR, DATA0, DATA1, ...]. Each completed data byte
//   produces a one-cycle register-write strobe. The sub-address auto-increments
//   after every data byte and wraps from 8'hFF to 8'h00.
//
// Ports
//   iCLK       system clock; all logic is synchronous to it
//   iRST_N     asynchronous active-low reset
//   I2C_SCLK   I2C clock from the master (never stretched here)
//   I2C_SDAT   open-drain I2C data; driven 1'b0 or released to 1'bz
//   oREG_ADDR  sub-address of the current write
//   oREG_DATA  data byte of the current write
//   oREG_WR    one-cycle write strobe; oREG_ADDR/oREG_DATA are valid with it
//   oBUSY      high from an acknowledged address until STOP or abort
//   oNACKED    sticky "frame not for us"; cleared by the next START
// ---------------------------------------------------------------------------
module i2c_cfg_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic [7:0] oREG_ADDR,
    output logic [7:0] oREG_DATA,
    output logic       oREG_WR,
    output logic       oBUSY,
    output logic       oNACKED
);

    localparam logic [7:0] WR_BYTE = {SLAVE_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_SUB,
        S_SUB_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_e;

    // -----------------------------------------------------------------------
    // Input conditioning: synchroniser chain then one edge-detect flop.
    // The chains reset to 1 (idle bus level) so that leaving reset never
    // fabricates a START from the flops themselves.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], I2C_SCLK};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], I2C_SDAT};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_ev;
    logic stop_ev;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise =  scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s &  scl_prev_q;
    // SDA moving while SCL is high is a bus condition, never a data bit.
    assign start_ev = ~sda_s &  sda_prev_q & scl_s;
    assign stop_ev  =  sda_s & ~sda_prev_q & scl_s;

    // -----------------------------------------------------------------------
    // Protocol FSM
    // -----------------------------------------------------------------------
    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] sub_q;
    logic       ack_phase_q;   // 0: waiting to drive ACK, 1: ACK on the wire
    logic       sda_oe_q;

    logic [7:0] byte_nxt;
    assign byte_nxt = {shift_q[6:0], sda_s};

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sub_q       <= '0;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            oREG_ADDR   <= '0;
            oREG_DATA   <= '0;
            oREG_WR     <= 1'b0;
            oBUSY       <= 1'b0;
            oNACKED     <= 1'b0;
        end else begin
            oREG_WR <= 1'b0;

            // Bus conditions take priority over any SCL edge in the same cycle.
            if (start_ev) begin
                state_q     <= S_ADDR;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                oBUSY       <= 1'b0;
                oNACKED     <= 1'b0;
            end else if (stop_ev) begin
                // Any partial byte is simply dropped.
                state_q     <= S_IDLE;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                oBUSY       <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_SUB, S_DATA: begin
                        if (scl_rise) begin
                            shift_q   <= byte_nxt;
                            bit_cnt_q <= bit_cnt_q + 3'd1;   // wraps to 0 after bit 8
                            if (bit_cnt_q == 3'd7) begin
                                case (state_q)
                                    S_ADDR: begin
                                        if (byte_nxt == WR_BYTE) begin
                                            state_q <= S_ADDR_ACK;
                                        end else begin
                                            oNACKED <= 1'b1;
                                            state_q <= S_IGNORE;
                                        end
                                    end
                                    S_SUB: begin
                                        sub_q   <= byte_nxt;
                                        state_q <= S_SUB_ACK;
                                    end
                                    default: state_q <= S_DATA_ACK;
                                endcase
                            end
                        end
                    end

                    // ACK slot: pull SDA low on the first SCL fall after bit 8,
                    // release it on the next fall (end of the 9th clock).
                    S_ADDR_ACK, S_SUB_ACK, S_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase_q) begin
                                ack_phase_q <= 1'b1;
                                sda_oe_q    <= 1'b1;
                                if (state_q == S_ADDR_ACK) begin
                                    oBUSY <= 1'b1;
                                end
                                if (state_q == S_DATA_ACK) begin
                                    oREG_WR   <= 1'b1;
                                    oREG_ADDR <= sub_q;
                                    oREG_DATA <= shift_q;
                                    sub_q     <= sub_q + 8'd1;
                                end
                            end else begin
                                ack_phase_q <= 1'b0;
                                sda_oe_q    <= 1'b0;
                                bit_cnt_q   <= '0;
                                state_q     <= (state_q == S_ADDR_ACK) ? S_SUB : S_DATA;
                            end
                        end
                    end

                    // IDLE and IGNORE only react to START/STOP above.
                    default: ;
                endcase
            end
        end
    end

    // Open-drain: only ever drive low.
    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_cfg_slave.sv
`timescale 1ns/1ps
// Testbench for i2c_cfg_slave: a bit-banged I2C master drives frames,
// write strobes are collected and compared with a frame-level model.
module tb_i2c_cfg_slave;

    localparam int SYNC = 2;
    localparam int Q    = 10;   // quarter SCL period in iCLK cycles
    localparam int HALF = 20;   // half SCL period in iCLK cycles

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] wq_t[$];

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic scl     = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;

    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_wr;
    logic       busy;
    logic       nacked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int viol = 0;
    logic [15:0] obs_q[$];
    int          lat_q[$];

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #10 clk = ~clk;

    i2c_cfg_slave #(.SLAVE_ADDR(7'h1A), .SYNC_STAGES(SYNC)) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .I2C_SCLK  (scl),
        .I2C_SDAT  (sda),
        .oREG_ADDR (reg_addr),
        .oREG_DATA (reg_data),
        .oREG_WR   (reg_wr),
        .oBUSY     (busy),
        .oNACKED   (nacked)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every strobe cycle and its distance from the last bit-8 SCL fall.
    always @(negedge clk) begin
        if (reg_wr === 1'b1) begin
            obs_q.push_back({reg_addr, reg_data});
            lat_q.push_back(cyc - last_fall);
        end
    end

    // The target may only change its SDA drive while SCL is low.
    wire dut_low = (sda === 1'b0) && !sda_low;
    logic prev_dut_low = 1'b0;
    logic prev_scl     = 1'b1;
    always @(posedge clk) begin
        if (rst_n && scl && prev_scl && (dut_low != prev_dut_low)) viol <= viol + 1;
        prev_dut_low <= dut_low;
        prev_scl     <= scl;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic wq_t model_writes(bq_t fr);
        wq_t q;
        logic [7:0] a;
        if (fr.size() >= 2 && fr[0] == 8'h34) begin
            a = fr[1];
            for (int i = 2; i < fr.size(); i++) begin
                q.push_back({a, fr[i]});
                a = a + 8'd1;
            end
        end
        return q;
    endfunction

    // ---------------- bus master ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(HALF);
        sda_low = 1'b1; tick(HALF);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; tick(Q);
        scl = 1'b1;     tick(HALF);
        sda_low = 1'b0; tick(HALF);
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_low = !b[i]; tick(Q);
            scl = 1'b1;      tick(HALF);
            scl = 1'b0;
            if (i == 0) last_fall = cyc;
            tick(Q);
        end
    endtask

    task automatic ack_bit(output bit ack);
        sda_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(HALF / 2);
        ack = (sda === 1'b0);
        tick(HALF / 2);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        write_bits(b, 8);
        ack_bit(ack);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({reg_addr, reg_data, reg_wr, busy, nacked} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {reg_addr, reg_data, reg_wr, busy, nacked});
        end
        checks++;
        if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", sda); end
        rst_n = 1'b1;
        tick(5);
        checks++;
        if (busy !== 1'b0 || reg_wr !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy %b wr %b exp 0 0", busy, reg_wr);
        end
    endtask

    task automatic test_basic();
        bq_t fr = '{8'h34, 8'h0E, 8'hC2};
        wq_t exp = '{16'h0EC2};
        bit a;
        int acks = 0;
        obs_q.delete();
        bus_start();
        write_byte(fr[0], a); acks += int'(a);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
        write_byte(fr[1], a); acks += int'(a);
        write_byte(fr[2], a); acks += int'(a);
        bus_stop();
        tick(10);
        checks++;
        if (acks != 3) begin errors++; $display("FAIL basic_acks got %0d exp 3", acks); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_stop got %b exp 0", busy); end
        checks++;
        if (nacked !== 1'b0) begin errors++; $display("FAIL basic_nacked got %b exp 0", nacked); end
        checks++;
        if (obs_q.size() != exp.size()) begin
            errors++; $display("FAIL basic_nwr got %0d exp %0d", obs_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp[i]) begin
                    errors++; $display("FAIL basic_wr%0d got %h exp %h", i, obs_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_nack();
        bq_t fr = '{8'h40, 8'h00, 8'h00};
        bit a;
        int acks = 0;
        obs_q.delete();
        bus_start();
        foreach (fr[i]) begin
            write_byte(fr[i], a); acks += int'(a);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy%0d got %b exp 0", i, busy); end
        end
        bus_stop();
        tick(10);
        checks++;
        if (acks != 0) begin errors++; $display("FAIL nack_acks got %0d exp 0", acks); end
        checks++;
        if (nacked !== 1'b1) begin errors++; $display("FAIL nack_sticky got %b exp 1", nacked); end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL nack_nwr got %0d exp 0", obs_q.size()); end
    endtask

    task automatic test_burst();
        wq_t exp = '{16'hFF02, 16'h0001};
        bit a;
        obs_q.delete();
        bus_start();
        checks++;
        if (nacked !== 1'b0) begin errors++; $display("FAIL burst_nack_clr got %b exp 0", nacked); end
        write_byte(8'h34, a);
        write_byte(8'hFF, a);
        write_byte(8'h02, a);
        write_byte(8'h01, a);
        bus_stop();
        tick(10);
        checks++;
        if (obs_q.size() != exp.size()) begin
            errors++; $display("FAIL burst_nwr got %0d exp %0d", obs_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp[i]) begin
                    errors++; $display("FAIL burst_wr%0d got %h exp %h", i, obs_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_partial();
        bit a;
        obs_q.delete();
        bus_start();
        write_byte(8'h34, a);
        write_byte(8'h10, a);
        write_bits(8'hA5, 4);
        bus_stop();
        tick(10);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL partial_nwr got %0d exp 0", obs_q.size()); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got %b exp 0", busy); end
        checks++;
        if (sda !== 1'b1) begin errors++; $display("FAIL partial_sda got %b exp 1", sda); end
    endtask

    task automatic test_restart();
        wq_t exp = '{16'h2055};
        bit a;
        int acks = 0;
        obs_q.delete();
        bus_start();
        write_byte(8'h34, a); acks += int'(a);
        write_byte(8'h10, a); acks += int'(a);
        bus_start();
        write_byte(8'h34, a); acks += int'(a);
        write_byte(8'h20, a); acks += int'(a);
        write_byte(8'h55, a); acks += int'(a);
        bus_stop();
        tick(10);
        checks++;
        if (acks != 5) begin errors++; $display("FAIL restart_acks got %0d exp 5", acks); end
        checks++;
        if (obs_q.size() != exp.size()) begin
            errors++; $display("FAIL restart_nwr got %0d exp %0d", obs_q.size(), exp.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp[0]) begin
                errors++; $display("FAIL restart_wr got %h exp %h", obs_q[0], exp[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit a;
        obs_q.delete();
        bus_start();
        write_byte(8'h34, a);
        write_bits(8'h10, 8);
        sda_low = 1'b0;
        tick(1);
        checks++;
        if (sda !== 1'b0) begin errors++; $display("FAIL rstmid_ack_drv got %b exp 0", sda); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sda !== 1'b1) begin errors++; $display("FAIL rstmid_sda got %b exp 1", sda); end
        tick(3);
        checks++;
        if ({reg_wr, busy, nacked, reg_addr, reg_data} !== 19'd0) begin
            errors++; $display("FAIL rstmid_outputs got %h exp 0", {reg_wr, busy, nacked, reg_addr, reg_data});
        end
        rst_n = 1'b1;
        tick(Q - 4);
        scl = 1'b1; tick(HALF);           // rest of the SUB ack clock
        scl = 1'b0; tick(Q);
        write_byte(8'h77, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL rstmid_ignored_ack got %b exp 0", a); end
        bus_stop();
        tick(10);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_nwr got %0d busy %b exp 0 0", obs_q.size(), busy);
        end
        bus_start();
        write_byte(8'h34, a);
        write_byte(8'h22, a);
        write_byte(8'h99, a);
        bus_stop();
        tick(10);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL rstmid_after_nwr got %0d exp 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== 16'h2299) begin
                errors++; $display("FAIL rstmid_after_wr got %h exp 2299", obs_q[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 15; f++) begin
            bq_t fr;
            wq_t exp;
            bit a;
            bit addressed;
            int acks = 0;
            int sel = $urandom_range(0, 3);
            int nd  = $urandom_range(0, 3);
            if (sel == 0)      fr.push_back(8'($urandom));
            else if (sel == 1) fr.push_back(8'h35);
            else               fr.push_back(8'h34);
            fr.push_back(8'($urandom));
            for (int i = 0; i < nd; i++) fr.push_back(8'($urandom));
            addressed = (fr[0] == 8'h34);
            exp = model_writes(fr);
            obs_q.delete();
            bus_start();
            foreach (fr[i]) begin
                write_byte(fr[i], a); acks += int'(a);
            end
            bus_stop();
            tick(10);
            checks++;
            if (acks != (addressed ? fr.size() : 0)) begin
                errors++; $display("FAIL rnd%0d_acks got %0d exp %0d", f, acks, addressed ? fr.size() : 0);
            end
            checks++;
            if (nacked !== !addressed) begin
                errors++; $display("FAIL rnd%0d_nacked got %b exp %b", f, nacked, !addressed);
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy got %b exp 0", f, busy); end
            checks++;
            if (obs_q.size() != exp.size()) begin
                errors++; $display("FAIL rnd%0d_nwr got %0d exp %0d", f, obs_q.size(), exp.size());
            end else begin
                for (int i = 0; i < exp.size(); i++) begin
                    checks++;
                    if (obs_q[i] !== exp[i]) begin
                        errors++; $display("FAIL rnd%0d_wr%0d got %h exp %h", f, i, obs_q[i], exp[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_timing();
        checks++;
        if (lat_q.size() == 0) begin errors++; $display("FAIL lat_count got 0 exp >0"); end
        foreach (lat_q[i]) begin
            checks++;
            if (lat_q[i] < SYNC + 1 || lat_q[i] > SYNC + 2) begin
                errors++; $display("FAIL lat%0d got %0d exp %0d..%0d", i, lat_q[i], SYNC + 1, SYNC + 2);
            end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL sda_while_scl_high got %0d exp 0", viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nack();
        test_burst();
        test_partial();
        test_restart();
        test_reset_mid();
        test_random();
        test_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
